// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared FSM state, funct3 size codes and size-class helpers for mem_access_unit
package mem_access_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic is_byte(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] sz);
    return (sz == SZ_H) || (sz == SZ_HU);
  endfunction

  // Anything that is not a byte or halfword, including undefined codes, acts as a word.
  function automatic logic is_word(input logic [2:0] sz);
    return !is_byte(sz) && !is_half(sz);
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - combinational byte-lane store merge and load extract/extend
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] i_word_q,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_mem_word,
  output logic [31:0] o_merged,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_merged = i_word_q;
    if (is_byte(i_size)) begin
      case (i_addr_lo)
        2'd0:    o_merged[7:0]   = i_wdata[7:0];
        2'd1:    o_merged[15:8]  = i_wdata[7:0];
        2'd2:    o_merged[23:16] = i_wdata[7:0];
        default: o_merged[31:24] = i_wdata[7:0];
      endcase
    end else if (is_half(i_size)) begin
      if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
      else              o_merged[15:0]  = i_wdata[15:0];
    end else begin
      o_merged = i_wdata;
    end
  end

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_mem_word[7:0];
      2'd1:    w_byte = i_mem_word[15:8];
      2'd2:    w_byte = i_mem_word[23:16];
      default: w_byte = i_mem_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_mem_word[31:16] : i_mem_word[15:0];
    case (i_size)
      SZ_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      SZ_BU:   o_rdata = {24'b0, w_byte};
      SZ_H:    o_rdata = {{16{w_half[15]}}, w_half};
      SZ_HU:   o_rdata = {16'b0, w_half};
      default: o_rdata = i_mem_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - core-side load/store initiator for the word RAM; MISALIGN_TRAP_EN adds a misaligned trap output
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_busy
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [DATA_W-1:0] r_wdata;
  logic              r_is_write;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_extract;
  logic              w_req;
  logic              w_mis;

  assign w_req    = req_read | req_write;
  assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
  assign rdata    = r_rdata;

`ifdef MISALIGN_TRAP_EN
  logic r_mis;
  assign w_mis = (is_half(req_size) && req_addr[0]) ||
                 (is_word(req_size) && (req_addr[1:0] != 2'b00));
  assign misaligned = (r_state == DONE) && r_mis;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                          r_mis <= 1'b0;
    else if (r_state == IDLE && w_req)  r_mis <= w_mis;
    else if (r_state == DONE)           r_mis <= 1'b0;
  end
`else
  assign w_mis = 1'b0;
`endif

  mem_lane_merge u_lane (
    .i_word_q   (r_word),
    .i_wdata    (r_wdata),
    .i_size     (r_size),
    .i_addr_lo  (r_addr[1:0]),
    .i_mem_word (mem_rdata),
    .o_merged   (w_merged),
    .o_rdata    (w_extract)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          stall = 1'b1;
          if (w_mis)                               w_next = DONE;
          else if (req_write && is_word(req_size)) w_next = WR;
          else                                     w_next = RD;
        end
      end
      RD: begin
        stall = 1'b1;
        if (!mem_busy) w_next = r_is_write ? WR : DONE;
      end
      WR: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = w_merged;
        if (!mem_busy) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Write wins when both request lines are high, so is_write just follows req_write.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_word     <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_wdata    <= req_wdata;
            r_is_write <= req_write;
            if (w_mis) r_rdata <= '0;
          end
        end
        RD: begin
          if (!mem_busy) begin
            r_word <= mem_rdata;
            if (!r_is_write) r_rdata <= w_extract;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit against a word-array reference model
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  req_size = 3'b0;
  logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
  logic        stall, done, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_busy = 1'b0;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .nRst(nRst),
    .req_read(req_read), .req_write(req_write), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy)
`ifdef MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  logic [31:0] ram     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rdata;

  assign mem_rdata = ram[mem_addr[7:2]];
  always @(posedge clk) if (mem_we && !mem_busy) ram[mem_addr[7:2]] <= mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] sz, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (sz)
      3'd0:    return b[7]  ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    case (sz)
      3'd0: begin
        mask = 32'hFF << (8 * a[1:0]);
        return (old & ~mask) | ((wd & 32'hFF) << (8 * a[1:0]));
      end
      3'd1: begin
        mask = 32'hFFFF << (16 * a[1]);
        return (old & ~mask) | ((wd & 32'hFFFF) << (16 * a[1]));
      end
      default: return wd;
    endcase
  endfunction

  function automatic logic ref_mis(input logic [2:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (sz == 3'd1 || sz == 3'd5) return a[0];
    if (sz == 3'd0 || sz == 3'd4) return 1'b0;
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // One request, checked end to end; busy cycles are inserted right after the request cycle.
  task automatic txn(input logic is_wr, input logic [2:0] sz, input logic [31:0] addr,
                     input logic [31:0] wd, input int busy, output logic [31:0] got);
    int lat, we_cyc, commits, stall_bad, busy_left, exp_lat, exp_we;
    logic mis, sub;
    logic [31:0] we_a, we_d, exp_word;
    logic [5:0] idx;
    idx      = addr[7:2];
    mis      = ref_mis(sz, addr);
    sub      = is_wr && (sz == 3'd0 || sz == 3'd1);
    exp_word = ref_store(ref_mem[idx], sz, addr, wd);
    exp_lat  = mis ? 2 : ((sub ? 4 : 3) + busy);
    exp_we   = (is_wr && !mis) ? (sub ? 1 : 1 + busy) : 0;
    lat = 0; we_cyc = 0; commits = 0; stall_bad = 0; busy_left = mis ? 0 : busy;
    we_a = 32'hx; we_d = 32'hx; got = 32'hx;
    @(negedge clk);
    req_read = !is_wr; req_write = is_wr; req_size = sz; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 40; c++) begin
      if (c >= 2 && busy_left > 0) begin mem_busy = 1'b1; busy_left--; end
      else mem_busy = 1'b0;
      #1;
      if (done) begin
        lat = c;
        got = rdata;
`ifdef MISALIGN_TRAP_EN
        check("misaligned_flag", 32'(misaligned), 32'(mis));
`endif
        break;
      end
      if (!stall) stall_bad++;
      if (mem_we) begin
        we_cyc++;
        if (!mem_busy) begin commits++; we_a = mem_addr; we_d = mem_wdata; end
      end
      @(negedge clk);
    end
    req_read = 1'b0; req_write = 1'b0; mem_busy = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_while_busy", 32'(stall_bad), 0);
    check("we_cycles", 32'(we_cyc), 32'(exp_we));
    check("commits", 32'(commits), (is_wr && !mis) ? 1 : 0);
    if (is_wr && !mis) begin
      check("we_addr", we_a, {addr[31:2], 2'b00});
      check("we_data", we_d, exp_word);
      ref_mem[idx] = exp_word;
    end
    if (mis)         exp_rdata = 32'h0;
    else if (!is_wr) exp_rdata = ref_load(ref_mem[idx], sz, addr);
    check("rdata", got, exp_rdata);
    @(negedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    check("idle_no_stall", 32'(stall), 0);
  endtask

  logic [31:0] got;
  logic [2:0]  load_sizes  [0:7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
  logic [2:0]  store_sizes [0:3] = '{3'd0, 3'd1, 3'd2, 3'd3};

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    exp_rdata = 32'h0;
    #2;
    check("rst_stall", 32'(stall), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;

    txn(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, got);
    check("sw_ram", ram[4], 32'hDEADBEEF);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0, got);
    check("lw_value", got, 32'hDEADBEEF);

    ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
    txn(1'b1, 3'd0, 32'h22, 32'h000000AA, 0, got);
    check("sb_ram", ram[8], 32'h11AA3344);

    ram[12] = 32'h8001FF80; ref_mem[12] = 32'h8001FF80;
    txn(1'b0, 3'd0, 32'h30, 32'h0, 0, got); check("lb", got, 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h30, 32'h0, 0, got); check("lbu", got, 32'h00000080);
    txn(1'b0, 3'd1, 32'h32, 32'h0, 0, got); check("lh", got, 32'hFFFF8001);
    txn(1'b0, 3'd5, 32'h32, 32'h0, 0, got); check("lhu", got, 32'h00008001);

    txn(1'b1, 3'd2, 32'h44, 32'hCAFEF00D, 3, got);
    check("busy_sw_ram", ram[17], 32'hCAFEF00D);

    txn(1'b1, 3'd1, 32'h32, 32'h0000BEEF, 2, got);

`ifdef MISALIGN_TRAP_EN
    txn(1'b0, 3'd2, 32'h41, 32'h0, 0, got);
    check("mis_lw_rdata", got, 32'h0);
`endif

    ram[20] = 32'h55667788; ref_mem[20] = 32'h55667788;
    @(negedge clk);
    req_write = 1'b1; req_size = 3'd1; req_addr = 32'h52; req_wdata = 32'h1234;
    @(negedge clk); #1;
    nRst = 1'b0; req_write = 1'b0;
    #1;
    check("rst_mid_stall", 32'(stall), 0);
    check("rst_mid_done", 32'(done), 0);
    check("rst_mid_we", 32'(mem_we), 0);
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_mid_ram", ram[20], 32'h55667788);
    check("rst_mid_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;

    for (int t = 0; t < 200; t++) begin
      logic wr;
      logic [2:0] sz;
      wr = 1'($urandom_range(0, 1));
      sz = wr ? store_sizes[$urandom_range(0, 3)] : load_sizes[$urandom_range(0, 7)];
      txn(wr, sz, 32'($urandom_range(0, 255)), $urandom, int'($urandom_range(0, 2)), got);
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
      check("ram_final_mismatch_words", 32'(bad), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
CPU-side initiator for the word-wide data RAM. Accepts load/store requests from the core (RISC-V funct3 sizes), drives the RAM's addr/write_enable/data_in, and honours the RAM busy output. Performs read-modify-write for SB/SH, since the RAM only writes whole words. Extracts and sign/zero-extends load data, and stalls the single-cycle core until the access is done.

Parameters:
ADDR_W, 32, byte-address width.
DATA_W, 32, RAM word width; fixed at 32, lane logic is 4 bytes.

Ports:
clk  in  1  clock.
nRst  in  1  reset, asynchronous, active-low.
req_read  in  1  load request from core; held until done.
req_write  in  1  store request from core; held until done.
req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
stall  out  1  freeze core PC/regfile writes.
done  out  1  one-cycle completion pulse.
rdata  out  32  extended load result; valid when done.
mem_addr  out  32  to RAM addr; always word-aligned ({addr[31:2],2'b00}).
mem_we  out  1  to RAM write_enable.
mem_wdata  out  32  to RAM data_in.
mem_rdata  in  32  from RAM data_out; combinational read of mem_addr.
mem_busy  in  1  RAM busy; while 1, the current state holds.

Behaviour:
- Reset: state IDLE. stall=0, done=0, rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, and all latches cleared.
- Reset mid-access: abort to IDLE. A write already clocked into the RAM stays committed; nothing further is issued.
- In IDLE, a request is latched into addr_q/size_q/wdata_q/is_write_q. If req_read and req_write are both high, write wins.
- stall = (IDLE & (req_read|req_write)) | RD | WR. stall is combinational.
- FSM states:
  - IDLE: a load or a sub-word store goes to RD. A word store goes to WR.
  - RD: mem_we=0. If !mem_busy, capture mem_rdata into word_q. A load then goes to DONE; a store goes to WR.
  - WR: mem_we=1, mem_wdata=merged word. If !mem_busy, go to DONE (RAM commits on this edge).
  - DONE: done=1, stall=0, rdata valid, then go to IDLE. Requests seen in DONE are not re-served, because the core retires in this cycle.
- Latency with mem_busy=0, counting the request cycle:
  - load: 3 cycles (IDLE, RD, DONE).
  - word store: 3 cycles (IDLE, WR, DONE).
  - sub-word store: 4 cycles (IDLE, RD, WR, DONE).
  - Each cycle of mem_busy=1 in RD or WR adds one cycle.
- Store merge:
  - B: lane addr[1:0] gets wdata[7:0].
  - H: lane addr[1] gets wdata[15:0].
  - W: wdata.
  - Other bytes come from word_q.
- Load extract: select the byte (addr[1:0]) or halfword (addr[1]).
  - 000 and 001 sign-extend; 100 and 101 zero-extend; 010 is the full word.
  - Undefined sizes (011, 110, 111) are treated as W.
- Misalignment (macro off): H ignores addr[0]; W ignores addr[1:0]. No error.
- rdata holds its last value until the next load reaches DONE. Stores leave rdata unchanged.

Optional Feature:
MISALIGN_TRAP_EN
- With it: adds port misaligned (out, 1, reset 0).
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - A misaligned request goes IDLE to DONE directly, with no RAM access and mem_we never asserted.
  - In DONE: misaligned=1, rdata=0.
- Without it: no port; behaviour as in the Misalignment rule above.

Decomposition:
- Package mem_access_pkg:
  - state enum {IDLE, RD, WR, DONE}.
  - funct3 size constants SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
- Sub-module mem_lane_merge: purely combinational.
  - Store-merge inputs: word_q, wdata, size, addr[1:0]; output: merged word.
  - Load-extract inputs: mem word, size, addr[1:0]; output: extended rdata.

Test Plan:
- Word store then load:
  - Stimulus: write addr 0x10, size 010, data 0xDEADBEEF, mem_busy=0.
  - Response: mem_we=1 in exactly one cycle with mem_addr=0x10; done on cycle 3.
  - Then a load from 0x10: rdata=0xDEADBEEF on done, cycle 3.
- Sub-word RMW:
  - Stimulus: RAM[0x20]=0x11223344; SB addr 0x22 data 0xAA.
  - Response: RD then WR; mem_wdata=0x11AA3344; done on cycle 4.
- Extension:
  - Stimulus: RAM[0x30]=0x8001FF80; LB 0x30, LBU 0x30, LH 0x32, LHU 0x32.
  - Response: rdata 0xFFFFFF80, 0x00000080, 0xFFFF8001, 0x00008001 respectively.
- Busy:
  - Stimulus: mem_busy=1 for 3 cycles during WR of a word store.
  - Response: state held, stall=1 throughout; mem_we stays 1; done 3 cycles later than nominal.
- Reset mid-access:
  - Stimulus: assert nRst=0 during RD of an SH.
  - Response: immediately stall=0, done=0, mem_we=0; RAM contents unchanged.
- MISALIGN_TRAP_EN:
  - Stimulus: LW at 0x41.
  - Response: done on cycle 2, misaligned=1, rdata=0, mem_we never 1.
